// File: rtl/aes_col_serializer.sv
// aes_col_serializer
// Captures one 4-column state block and streams its columns one per accepted
// beat. The column index is carried on the mux select pair S1S0 using the
// downstream cell's Gray coding (00, 01, 11, 10). It also counts completed
// blocks and reports busy status.
module aes_col_serializer #(
    parameter int COL_W = 32,
    parameter int CNT_W = 8
) (
    input  logic               CLK,
    input  logic               RSTB,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [4*COL_W-1:0] IN_DATA,
    input  logic               ABORT,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [COL_W-1:0]   OUT_DATA,
    output logic               OUT_LAST,
    output logic               S1,
    output logic               S0,
    output logic               BUSY,
    output logic [CNT_W-1:0]   BLK_CNT
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    // Select codes as seen by the mux cell: col0->IN1, col1->IN3, col2->IN4, col3->IN2
    localparam logic [1:0] SEL_C0 = 2'b00;
    localparam logic [1:0] SEL_C1 = 2'b01;
    localparam logic [1:0] SEL_C2 = 2'b11;
    localparam logic [1:0] SEL_C3 = 2'b10;

    state_e               state_q, state_d;
    logic [1:0]           sel_q, sel_d;
    logic [4*COL_W-1:0]   hold_q, hold_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;

    logic                 last_s;
    logic                 in_ready_s;
    logic [COL_W-1:0]     col_s;

    // Gray-sequence successor of a select code
    function automatic logic [1:0] sel_next(input logic [1:0] sel);
        logic [1:0] nxt;
        case (sel)
            SEL_C0:  nxt = SEL_C1;
            SEL_C1:  nxt = SEL_C2;
            SEL_C2:  nxt = SEL_C3;
            SEL_C3:  nxt = SEL_C0;
            default: nxt = SEL_C0;
        endcase
        return nxt;
    endfunction

    // Column mux driven by the same select coding as the downstream cell
    always_comb begin
        col_s = hold_q[4*COL_W-1 -: COL_W];
        case (sel_q)
            SEL_C0:  col_s = hold_q[4*COL_W-1 -: COL_W];
            SEL_C1:  col_s = hold_q[3*COL_W-1 -: COL_W];
            SEL_C2:  col_s = hold_q[2*COL_W-1 -: COL_W];
            SEL_C3:  col_s = hold_q[COL_W-1 -: COL_W];
            default: col_s = hold_q[4*COL_W-1 -: COL_W];
        endcase
    end

    // Last-beat decode and input handshake; ABORT blocks any capture
    always_comb begin
        last_s     = (state_q == ST_SEND) && (sel_q == SEL_C3);
        in_ready_s = !ABORT && ((state_q == ST_IDLE) || (last_s && OUT_READY));
    end

    // Next-state logic: ABORT first, then load / advance / finish
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        if (ABORT) begin
            state_d = ST_IDLE;
            sel_d   = SEL_C0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (IN_VALID) begin
                        hold_d  = IN_DATA;
                        sel_d   = SEL_C0;
                        state_d = ST_SEND;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (OUT_READY) begin
                        if (sel_q == SEL_C3) begin
                            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                            sel_d = SEL_C0;
                            if (IN_VALID) begin
                                hold_d  = IN_DATA;
                                state_d = ST_SEND;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            sel_d = sel_next(sel_q);
                        end
                    end else begin
                        sel_d = sel_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    sel_d   = SEL_C0;
                end
            endcase
        end
        valid_d = (state_d == ST_SEND);
        busy_d  = (state_d == ST_SEND);
    end

    // State, select, holding register, counter and status flops
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q <= ST_IDLE;
            sel_q   <= SEL_C0;
            hold_q  <= {(4*COL_W){1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign IN_READY  = in_ready_s;
    assign OUT_VALID = valid_q;
    assign OUT_DATA  = col_s;
    assign OUT_LAST  = last_s;
    assign S1        = sel_q[1];
    assign S0        = sel_q[0];
    assign BUSY      = busy_q;
    assign BLK_CNT   = cnt_q;

endmodule

// File: tb/tb_aes_col_serializer.sv
// Scoreboard bench for aes_col_serializer: the stimulus process drives
// directed and random traffic; the monitor keeps a block-level model
// (queue of pending columns) and compares every output each cycle.
module tb_aes_col_serializer;

    logic         CLK;
    logic         RSTB;
    logic         IN_VALID;
    logic         IN_READY;
    logic [127:0] IN_DATA;
    logic         ABORT;
    logic         OUT_VALID;
    logic         OUT_READY;
    logic [31:0]  OUT_DATA;
    logic         OUT_LAST;
    logic         S1;
    logic         S0;
    logic         BUSY;
    logic [7:0]   BLK_CNT;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] col;
        logic [1:0]  sel;
        bit          last;
    } beat_t;

    beat_t        exp_q[$];
    logic [7:0]   m_cnt = 8'd0;
    logic [127:0] m_last_blk = 128'd0;
    logic [1:0]   sel_tbl [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    aes_col_serializer #(.COL_W(32), .CNT_W(8)) dut (
        .CLK       (CLK),
        .RSTB      (RSTB),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_DATA   (IN_DATA),
        .ABORT     (ABORT),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_DATA  (OUT_DATA),
        .OUT_LAST  (OUT_LAST),
        .S1        (S1),
        .S0        (S0),
        .BUSY      (BUSY),
        .BLK_CNT   (BLK_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: compare outputs against the model, then advance
    // the model for the coming clock edge.
    always @(negedge CLK) begin
        bit          e_valid;
        logic [31:0] e_data;
        logic [1:0]  e_sel;
        bit          e_last;
        bit          e_rdy;
        if (!RSTB) begin
            exp_q.delete();
            m_cnt      = 8'd0;
            m_last_blk = 128'd0;
        end
        e_valid = (exp_q.size() != 0);
        if (e_valid) begin
            e_data = exp_q[0].col;
            e_sel  = exp_q[0].sel;
            e_last = exp_q[0].last;
        end else begin
            e_data = m_last_blk[127:96];
            e_sel  = 2'b00;
            e_last = 1'b0;
        end
        e_rdy = !ABORT && (!e_valid || (e_last && OUT_READY));
        check("out_valid", {63'd0, OUT_VALID}, {63'd0, e_valid});
        check("busy",      {63'd0, BUSY},      {63'd0, e_valid});
        check("out_data",  {32'd0, OUT_DATA},  {32'd0, e_data});
        check("s1s0",      {62'd0, S1, S0},    {62'd0, e_sel});
        check("out_last",  {63'd0, OUT_LAST},  {63'd0, e_last});
        check("in_ready",  {63'd0, IN_READY},  {63'd0, e_rdy});
        check("blk_cnt",   {56'd0, BLK_CNT},   {56'd0, m_cnt});
        if (RSTB) begin
            if (ABORT) begin
                exp_q.delete();
            end else begin
                if (e_valid && OUT_READY) begin
                    if (exp_q[0].last) m_cnt = m_cnt + 8'd1;
                    void'(exp_q.pop_front());
                end
                if (IN_VALID && e_rdy) begin
                    m_last_blk = IN_DATA;
                    for (int k = 0; k < 4; k++)
                        exp_q.push_back('{IN_DATA[(3-k)*32 +: 32], sel_tbl[k], (k == 3)});
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Offer a block and hold it until the handshake edge has passed
    task automatic send_block(input logic [127:0] blk);
        int t;
        IN_VALID = 1'b1;
        IN_DATA  = blk;
        t = 0;
        while (1) begin
            @(negedge CLK);
            if (IN_READY) break;
            t++;
            if (t > 64) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: got no IN_READY expected IN_READY within 64 cycles");
                break;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        RSTB      = 1'b0;
        IN_VALID  = 1'b0;
        IN_DATA   = 128'd0;
        ABORT     = 1'b0;
        OUT_READY = 1'b0;
        repeat (3) tick();
        RSTB = 1'b1;
        repeat (2) tick();

        // Single block, no backpressure
        OUT_READY = 1'b1;
        send_block(128'h00112233_44556677_8899AABB_CCDDEEFF);
        IN_VALID = 1'b0;
        repeat (6) tick();

        // Backpressure on cycles 2-4 of a block
        send_block(rnd128());
        IN_VALID = 1'b0;
        tick();
        OUT_READY = 1'b0;
        repeat (3) tick();
        OUT_READY = 1'b1;
        repeat (5) tick();

        // Back-to-back blocks
        send_block(128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3);
        send_block(128'h10203040_50607080_90A0B0C0_D0E0F000);
        IN_VALID = 1'b0;
        repeat (10) tick();

        // ABORT while S1S0 = 11
        send_block(rnd128());
        IN_VALID = 1'b0;
        repeat (2) tick();
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        repeat (3) tick();

        // ABORT coinciding with last beat and a new block offered
        send_block(rnd128());
        IN_VALID = 1'b0;
        repeat (3) tick();
        ABORT    = 1'b1;
        IN_VALID = 1'b1;
        IN_DATA  = rnd128();
        tick();
        ABORT    = 1'b0;
        IN_VALID = 1'b0;
        repeat (3) tick();

        // Counter wrap: 256 back-to-back blocks
        for (int b = 0; b < 256; b++) send_block(rnd128());
        IN_VALID = 1'b0;
        repeat (6) tick();

        // Random traffic with occasional abort and one mid-block reset
        for (int i = 0; i < 3000; i++) begin
            IN_VALID  = ($urandom_range(0, 99) < 60);
            IN_DATA   = rnd128();
            OUT_READY = ($urandom_range(0, 99) < 70);
            ABORT     = ($urandom_range(0, 99) < 3);
            if (i == 1500) RSTB = 1'b0;
            if (i == 1503) RSTB = 1'b1;
            tick();
        end
        IN_VALID  = 1'b0;
        ABORT     = 1'b0;
        OUT_READY = 1'b1;
        repeat (8) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_col_serializer.md
# aes_col_serializer

Serializer that sits directly upstream of the 4:1 column-select mux array in the AES-128 datapath. It captures one 128-bit state block, then drives the two mux select lines through the cell's select coding so that the four 32-bit columns appear one per accepted beat on a valid/ready stream. It also reports completed-block count and busy status for the round controller.

## Interface

- COL_W, 32, column width in bits; block width is 4*COL_W.
- CNT_W, 8, width of completed-block counter.

- CLK  in  1  rising-edge clock.
- RSTB  in  1  asynchronous active-low reset.
- IN_VALID  in  1  upstream block valid.
- IN_READY  out  1  block accepted when IN_VALID && IN_READY at a CLK edge.
- IN_DATA  in  4*COL_W  state block; column 0 = IN_DATA[4*COL_W-1:3*COL_W], column 3 = IN_DATA[COL_W-1:0].
- ABORT  in  1  synchronous flush; drops the current block.
- OUT_VALID  out  1  current column valid.
- OUT_READY  in  1  downstream accepts column when OUT_VALID && OUT_READY.
- OUT_DATA  out  COL_W  current column.
- OUT_LAST  out  1  high with column 3.
- S1, S0  out  1 each  mux select lines to the downstream 4:1 mux array.
- BUSY  out  1  high while a block is held.
- BLK_CNT  out  CNT_W  number of blocks fully emitted, modulo 2^CNT_W.

## Operation

- Select coding is fixed by the mux cell: S1S0 = 00 -> IN1, 01 -> IN3, 11 -> IN4, 10 -> IN2. Columns map to IN1=col0, IN3=col1, IN4=col2, IN2=col3, so emission order drives S1S0 as 00, 01, 11, 10 (Gray sequence). The internal OUT_DATA mux uses the same coding.
- FSM states: IDLE, SEND.
  - IDLE: IN_READY=1, OUT_VALID=0, BUSY=0. On IN_VALID: load 128-bit holding register, S1S0<=00, go SEND.
  - SEND: OUT_VALID=1, BUSY=1. On OUT_VALID&&OUT_READY: advance S1S0 along 00->01->11->10. On the beat with S1S0=10 (OUT_LAST=1) accepted: BLK_CNT increments; if IN_VALID also high, the next block is loaded, S1S0<=00, stay SEND; else go IDLE, S1S0<=00.
- IN_READY = IDLE || (SEND && OUT_LAST && OUT_READY); combinational from state and OUT_READY.
- OUT_LAST = SEND && S1S0==10.
- No advance while OUT_READY=0: OUT_DATA, S1, S0, OUT_LAST hold stable.
- ABORT has priority over all other events: next state IDLE, S1S0<=00, holding register unchanged, BLK_CNT not incremented even if it coincides with the last beat; IN_READY forced 0 in the ABORT cycle (no capture).
- BLK_CNT wraps from 2^CNT_W-1 to 0.
- Holding register loads only on accepted input; OUT_DATA in IDLE shows column selected by S1S0=00 of the last held block (don't-care for downstream, but deterministic).

## Timing

- Reset (RSTB=0, asynchronous): state IDLE, S1S0=00, holding register 0, BLK_CNT=0; hence OUT_VALID=0, OUT_LAST=0, BUSY=0, OUT_DATA=0, IN_READY=1 (subject to ABORT=0).
- Reset deassertion mid-block: block is lost; no partial output after reset.
- Latency: input accepted at edge N -> column 0 on OUT_DATA with OUT_VALID=1 in cycle after edge N.
- Throughput: one column per cycle with OUT_READY held high; back-to-back blocks at 4 cycles per block with no idle cycle.
- S1, S0, OUT_VALID, BUSY, BLK_CNT are register outputs; OUT_DATA and OUT_LAST are decoded from registers only (no input-to-output path). IN_READY is the only combinational input-to-output path (OUT_READY, ABORT).

## Test plan

- Reset then idle: RSTB low -> OUT_VALID=0, S1S0=00, BLK_CNT=0, IN_READY=1, OUT_DATA=0.
- Single block 0x00112233_44556677_8899AABB_CCDDEEFF, OUT_READY=1 -> four cycles OUT_DATA 00112233, 44556677, 8899AABB, CCDDEEFF with S1S0 00,01,11,10, OUT_LAST on 4th only, BLK_CNT=1, then IDLE.
- Backpressure: OUT_READY low on cycles 2-4 of a block -> column 1 and S1S0=01 held stable for 3 cycles, then sequence resumes; total 7 cycles.
- Back-to-back: IN_VALID held with two blocks, OUT_READY=1 -> 8 consecutive valid beats, IN_READY high only in IDLE and on the last beat, BLK_CNT=2.
- ABORT on beat with S1S0=11 -> next cycle OUT_VALID=0, S1S0=00, BLK_CNT unchanged; ABORT coinciding with OUT_LAST && IN_VALID -> no capture, BLK_CNT unchanged.
- Counter wrap: CNT_W=8, emit 256 blocks -> BLK_CNT returns to 0.
